// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module      : seq_restoring_divider
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock. Computes Q = A / B and R = A % B behind a start/done
//               handshake. Each iteration performs a trial subtract
//               (P + ~B + 1) and restores the partial remainder on borrow.
//               A zero divisor short-circuits to DONE with Q = all ones,
//               R = A and div_by_zero set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  // Iteration counter only needs to reach WIDTH-1
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_b;
  // Partial remainder is one bit wider so the trial subtract's sign is visible
  logic [WIDTH:0]   r_p;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;
  logic [WIDTH:0]   w_p_next;
  logic [WIDTH-1:0] w_div_next;

  // One restoring-division step: shift in next dividend bit, trial subtract, restore on borrow
  always_comb begin
    w_p_shift  = {r_p[WIDTH-1:0], r_div[WIDTH-1]};
    w_trial    = w_p_shift + ~{1'b0, r_b} + {{WIDTH{1'b0}}, 1'b1};
    w_q_bit    = ~w_trial[WIDTH];
    w_p_next   = w_q_bit ? w_trial : w_p_shift;
    w_div_next = {r_div[WIDTH-2:0], w_q_bit};
  end

  // Control FSM and datapath registers; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      // done is a pulse unless re-asserted below
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          busy <= 1'b0;
          if (start) begin
            r_div <= A;
            r_b   <= B;
            r_p   <= '0;
            r_cnt <= c_CNT_LAST;
            if (B == '0) begin
              // Zero divisor: no iterations, report immediately
              Q           <= {WIDTH{1'b1}};
              R           <= A;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              busy    <= 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          r_p   <= w_p_next;
          r_div <= w_div_next;
          if (r_cnt == '0) begin
            Q           <= w_div_next;
            R           <= w_p_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            busy  <= 1'b1;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Self-checking bench for seq_restoring_divider (WIDTH = 4).
//               Table-driven directed vectors, multi-cycle corner cases and
//               a full 4-bit operand sweep against a behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to done; reports edges-to-done and busy samples
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int busy_cnt);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  vec_t tbl[8];
  int   lat;
  int   bcnt;
  int   ndone;
  int   first_q;
  int   first_r;
  int   t0;
  int   t1;

  initial begin
    tbl[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dbz: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
    tbl[2] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3, dbz: 1'b0};
    tbl[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
    tbl[4] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, dbz: 1'b1};
    tbl[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0};
    tbl[6] = '{a: 4'd12, b: 4'd3,  q: 4'd4,  r: 4'd0, dbz: 1'b0};
    tbl[7] = '{a: 4'd14, b: 4'd5,  q: 4'd2,  r: 4'd4, dbz: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    tick();
    tick();
    chk("reset_Q", Q, 0);
    chk("reset_R", R, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat, bcnt);
      chk($sformatf("tbl%0d_latency", i), lat, (tbl[i].b == 0) ? 0 : WIDTH);
      chk($sformatf("tbl%0d_busy_cycles", i), bcnt, (tbl[i].b == 0) ? 0 : WIDTH);
      chk($sformatf("tbl%0d_done", i), done, 1);
      chk($sformatf("tbl%0d_Q", i), Q, tbl[i].q);
      chk($sformatf("tbl%0d_R", i), R, tbl[i].r);
      chk($sformatf("tbl%0d_dbz", i), div_by_zero, tbl[i].dbz);
      tick();
      chk($sformatf("tbl%0d_done_pulse", i), done, 0);
      chk($sformatf("tbl%0d_hold_Q", i), Q, tbl[i].q);
    end

    // start pulses during RUN must be ignored
    A = 4'd13;
    B = 4'd4;
    start = 1'b1;
    tick();
    A = 4'd9;
    B = 4'd2;
    ndone = 0;
    first_q = -1;
    first_r = -1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0 || i == 2);
      if (done) begin
        ndone++;
        first_q = Q;
        first_r = R;
      end
      tick();
    end
    start = 1'b0;
    chk("ignore_start_ndone", ndone, 1);
    chk("ignore_start_Q", first_q, 3);
    chk("ignore_start_R", first_r, 1);

    // Asynchronous reset mid-operation
    A = 4'd13;
    B = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_Q", Q, 0);
    chk("midrst_R", R, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_op(4'd10, 4'd3, lat, bcnt);
    chk("after_rst_latency", lat, WIDTH);
    chk("after_rst_Q", Q, 3);
    chk("after_rst_R", R, 1);
    tick();

    // Back-to-back with start held high through DONE
    A = 4'd13;
    B = 4'd4;
    start = 1'b1;
    tick();
    t0 = 0;
    while (!done && t0 < 20) begin
      tick();
      t0++;
    end
    chk("b2b_first_done", done, 1);
    chk("b2b_first_Q", Q, 3);
    chk("b2b_first_R", R, 1);
    A = 4'd14;
    B = 4'd5;
    t1 = 0;
    tick();
    t1++;
    start = 1'b0;
    while (!done && t1 < 20) begin
      tick();
      t1++;
    end
    chk("b2b_spacing", t1, WIDTH + 1);
    chk("b2b_second_Q", Q, 2);
    chk("b2b_second_R", R, 4);
    tick();

    // Full operand sweep against a behavioural reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int eq;
        int er;
        run_op(4'(a), 4'(b), lat, bcnt);
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        chk($sformatf("sweep_%0d_%0d_done", a, b), done, 1);
        chk($sformatf("sweep_%0d_%0d_Q", a, b), Q, eq);
        chk($sformatf("sweep_%0d_%0d_R", a, b), R, er);
        chk($sformatf("sweep_%0d_%0d_dbz", a, b), div_by_zero, (b == 0) ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
